// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types: axis phases, per-axis phase lengths and helpers
// that derive an axis total and the first position of its active area.
package vga_timing_pkg;

    localparam int COORD_W   = 11;
    localparam int MAX_TOTAL = 2047;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {FRONT, SYNC, BACK, DISP} vga_phase_t;

    typedef struct packed {
        coord_t disp;
        coord_t front;
        coord_t sync;
        coord_t back;
    } vga_axis_cfg_t;

    function automatic coord_t axis_total(input vga_axis_cfg_t cfg);
        return cfg.disp + cfg.front + cfg.sync + cfg.back;
    endfunction

    function automatic coord_t axis_disp_start(input vga_axis_cfg_t cfg);
        return cfg.front + cfg.sync + cfg.back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical). count_o/phase_o/coord_o describe the
// position entered on the next edge, so the parent can register them aligned.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter vga_axis_cfg_t RST_CFG = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          adv_i,
    input  logic          load_i,
    input  vga_axis_cfg_t cfg_i,
    output coord_t        count_o,
    output vga_phase_t    phase_o,
    output logic          wrap_o,
    output coord_t        coord_o
);

    vga_axis_cfg_t cfg_q, cfg_d;
    coord_t        count_q, count_d;
    coord_t        back_start, disp_start;

    // Current position is the last one of the axis.
    assign wrap_o = (count_q == axis_total(cfg_q) - coord_t'(1));

    always_comb begin
        cfg_d   = load_i ? cfg_i : cfg_q;
        count_d = count_q;
        if (clear_i || load_i) begin
            count_d = '0;
        end else if (adv_i) begin
            count_d = wrap_o ? '0 : count_q + coord_t'(1);
        end

        back_start = cfg_d.front + cfg_d.sync;
        disp_start = axis_disp_start(cfg_d);
        phase_o    = DISP;
        if (count_d < cfg_d.front) begin
            phase_o = FRONT;
        end else if (count_d < back_start) begin
            phase_o = SYNC;
        end else if (count_d < disp_start) begin
            phase_o = BACK;
        end
        coord_o = (phase_o == DISP) ? count_d - disp_start : '0;
        count_o = count_d;
    end

    // NOTE: reset is synchronous here, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q   <= RST_CFG;
            count_q <= '0;
        end else begin
            cfg_q   <= cfg_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_frame_sequencer.sv
// Full-frame VGA timing with two fixed modes switched at frame boundaries.
// Optional VGA_SYNC_POL_EN adds per-mode sync polarity parameters.
module vga_frame_sequencer
    import vga_timing_pkg::*;
#(
    parameter int unsigned MODE0_H_DISP  = 1280,
    parameter int unsigned MODE0_H_FRONT = 48,
    parameter int unsigned MODE0_H_SYNC  = 112,
    parameter int unsigned MODE0_H_BACK  = 248,
    parameter int unsigned MODE0_V_DISP  = 1024,
    parameter int unsigned MODE0_V_FRONT = 1,
    parameter int unsigned MODE0_V_SYNC  = 3,
    parameter int unsigned MODE0_V_BACK  = 38,
    parameter int unsigned MODE1_H_DISP  = 640,
    parameter int unsigned MODE1_H_FRONT = 16,
    parameter int unsigned MODE1_H_SYNC  = 96,
    parameter int unsigned MODE1_H_BACK  = 48,
    parameter int unsigned MODE1_V_DISP  = 480,
    parameter int unsigned MODE1_V_FRONT = 10,
    parameter int unsigned MODE1_V_SYNC  = 2,
    parameter int unsigned MODE1_V_BACK  = 33
`ifdef VGA_SYNC_POL_EN
    ,
    parameter bit MODE0_HSYNC_POS = 1'b1,
    parameter bit MODE0_VSYNC_POS = 1'b1,
    parameter bit MODE1_HSYNC_POS = 1'b0,
    parameter bit MODE1_VSYNC_POS = 1'b0
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode_req,
    input  logic               mode_sel,
    output logic               mode_ack,
    output logic               mode_cur,
    output logic               hsync_n,
    output logic               vsync_n,
    output logic               disp_en,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic               line_start,
    output logic               frame_start
);

    localparam int unsigned M0_H_TOTAL = MODE0_H_DISP + MODE0_H_FRONT + MODE0_H_SYNC + MODE0_H_BACK;
    localparam int unsigned M0_V_TOTAL = MODE0_V_DISP + MODE0_V_FRONT + MODE0_V_SYNC + MODE0_V_BACK;
    localparam int unsigned M1_H_TOTAL = MODE1_H_DISP + MODE1_H_FRONT + MODE1_H_SYNC + MODE1_H_BACK;
    localparam int unsigned M1_V_TOTAL = MODE1_V_DISP + MODE1_V_FRONT + MODE1_V_SYNC + MODE1_V_BACK;

    if (M0_H_TOTAL > MAX_TOTAL || M0_V_TOTAL > MAX_TOTAL ||
        M1_H_TOTAL > MAX_TOTAL || M1_V_TOTAL > MAX_TOTAL) begin : g_total_check
        $error("vga_frame_sequencer: an axis total exceeds 2047");
    end

    localparam vga_axis_cfg_t M0_H_CFG = '{disp: coord_t'(MODE0_H_DISP), front: coord_t'(MODE0_H_FRONT),
                                           sync: coord_t'(MODE0_H_SYNC), back: coord_t'(MODE0_H_BACK)};
    localparam vga_axis_cfg_t M0_V_CFG = '{disp: coord_t'(MODE0_V_DISP), front: coord_t'(MODE0_V_FRONT),
                                           sync: coord_t'(MODE0_V_SYNC), back: coord_t'(MODE0_V_BACK)};
    localparam vga_axis_cfg_t M1_H_CFG = '{disp: coord_t'(MODE1_H_DISP), front: coord_t'(MODE1_H_FRONT),
                                           sync: coord_t'(MODE1_H_SYNC), back: coord_t'(MODE1_H_BACK)};
    localparam vga_axis_cfg_t M1_V_CFG = '{disp: coord_t'(MODE1_V_DISP), front: coord_t'(MODE1_V_FRONT),
                                           sync: coord_t'(MODE1_V_SYNC), back: coord_t'(MODE1_V_BACK)};

    logic       run_q, mode_cur_q, mode_d, pend_valid_q, pend_valid_d, pending_q, pending_d;
    logic       mode_ack_q, hsync_n_q, vsync_n_q, disp_en_q, line_start_q, frame_start_q;
    coord_t     px_x_q, px_y_q;
    logic       hsync_n_d, vsync_n_d, disp_en_d;
    coord_t     px_x_d, px_y_d;
    logic       apply, accept, hs_pos, vs_pos;
    coord_t     h_count, v_count, h_coord, v_coord;
    vga_phase_t h_phase, v_phase;
    logic       h_wrap, v_wrap;

`ifdef VGA_SYNC_POL_EN
    localparam logic HS_IDLE = ~MODE0_HSYNC_POS;
    localparam logic VS_IDLE = ~MODE0_VSYNC_POS;
    assign hs_pos = mode_d ? MODE1_HSYNC_POS : MODE0_HSYNC_POS;
    assign vs_pos = mode_d ? MODE1_VSYNC_POS : MODE0_VSYNC_POS;
`else
    localparam logic HS_IDLE = 1'b1;
    localparam logic VS_IDLE = 1'b1;
    assign hs_pos = 1'b0;
    assign vs_pos = 1'b0;
`endif

    // The ack cycle is still part of the finished handshake, so it cannot start a new one.
    assign apply  = run_q && h_wrap && v_wrap && pend_valid_q;
    assign accept = mode_req && !pend_valid_q && !mode_ack_q;

    vga_axis_counter #(.RST_CFG(M0_H_CFG)) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .clear_i (!run_q),
        .adv_i   (1'b1),
        .load_i  (apply),
        .cfg_i   (pending_q ? M1_H_CFG : M0_H_CFG),
        .count_o (h_count),
        .phase_o (h_phase),
        .wrap_o  (h_wrap),
        .coord_o (h_coord)
    );

    vga_axis_counter #(.RST_CFG(M0_V_CFG)) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .clear_i (!run_q),
        .adv_i   (h_wrap),
        .load_i  (apply),
        .cfg_i   (pending_q ? M1_V_CFG : M0_V_CFG),
        .count_o (v_count),
        .phase_o (v_phase),
        .wrap_o  (v_wrap),
        .coord_o (v_coord)
    );

    always_comb begin
        mode_d       = mode_cur_q;
        pend_valid_d = pend_valid_q;
        pending_d    = pending_q;
        if (apply) begin
            mode_d       = pending_q;
            pend_valid_d = 1'b0;
        end else if (accept) begin
            pend_valid_d = 1'b1;
            pending_d    = mode_sel;
        end

        hsync_n_d = (h_phase == SYNC) ? hs_pos : ~hs_pos;
        vsync_n_d = (v_phase == SYNC) ? vs_pos : ~vs_pos;
        disp_en_d = (h_phase == DISP) && (v_phase == DISP);
        px_x_d    = disp_en_d ? h_coord : '0;
        px_y_d    = disp_en_d ? v_coord : '0;
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q         <= 1'b0;
            mode_cur_q    <= 1'b0;
            pend_valid_q  <= 1'b0;
            pending_q     <= 1'b0;
            mode_ack_q    <= 1'b0;
            hsync_n_q     <= HS_IDLE;
            vsync_n_q     <= VS_IDLE;
            disp_en_q     <= 1'b0;
            px_x_q        <= '0;
            px_y_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            run_q         <= 1'b1;
            mode_cur_q    <= mode_d;
            pend_valid_q  <= pend_valid_d;
            pending_q     <= pending_d;
            mode_ack_q    <= apply;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            disp_en_q     <= disp_en_d;
            px_x_q        <= px_x_d;
            px_y_q        <= px_y_d;
            line_start_q  <= (h_count == '0);
            frame_start_q <= (h_count == '0) && (v_count == '0);
        end
    end

    assign mode_ack    = mode_ack_q;
    assign mode_cur    = mode_cur_q;
    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;
    assign disp_en     = disp_en_q;
    assign px_x        = px_x_q;
    assign px_y        = px_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_frame_sequencer.md
# vga_frame_sequencer

Full-frame VGA timing controller. It sequences one horizontal and one vertical position counter through the front-porch, sync, back-porch and active phases, producing sync, display-enable and pixel coordinates. It also switches between two fixed video modes through a request/acknowledge handshake applied only at frame boundaries. It sits between the pixel-clock domain root and the pixel fetch/colour output logic.

## Interface
- `MODE0_H_DISP` / `_FRONT` / `_SYNC` / `_BACK`, default 1280 / 48 / 112 / 248: horizontal phases for mode 0, in pixels.
- `MODE0_V_DISP` / `_FRONT` / `_SYNC` / `_BACK`, default 1024 / 1 / 3 / 38: vertical phases for mode 0, in lines.
- `MODE1_H_DISP` / `_FRONT` / `_SYNC` / `_BACK`, default 640 / 16 / 96 / 48: horizontal phases for mode 1.
- `MODE1_V_DISP` / `_FRONT` / `_SYNC` / `_BACK`, default 480 / 10 / 2 / 33: vertical phases for mode 1.
- `clk` input 1: pixel clock; the only clock.
- `rst` input 1: synchronous, active-high reset.
- `mode_req` input 1: mode-change request level.
- `mode_sel` input 1: requested mode; sampled when a request is accepted.
- `mode_ack` output 1: one-cycle pulse when the requested mode takes effect.
- `mode_cur` output 1: mode currently being generated.
- `hsync_n` output 1: horizontal sync, active low.
- `vsync_n` output 1: vertical sync, active low.
- `disp_en` output 1: high when both axes are in the active phase.
- `px_x` output 11: active pixel column; 0 outside the active area.
- `px_y` output 11: active line; 0 outside the active area.
- `line_start` output 1: pulse at horizontal position 0.
- `frame_start` output 1: pulse at horizontal and vertical position 0.

## Operation
- Each axis has a phase sequence FRONT → SYNC → BACK → DISP → FRONT.
- The horizontal counter runs 0 … H_TOTAL−1, then wraps to 0.
  - FRONT covers 0 … F−1; SYNC covers F … F+S−1; BACK covers F+S … F+S+B−1; DISP covers F+S+B … TOTAL−1.
- The vertical counter has the same phase layout, in lines. It advances only on a horizontal wrap and wraps at V_TOTAL−1.
- `hsync_n` is low while the horizontal axis is in SYNC. `vsync_n` is low while the vertical axis is in SYNC.
- `disp_en` = horizontal DISP AND vertical DISP.
- `px_x` = h_count − (F+S+B) while `disp_en`; otherwise 0. `px_y` is derived the same way from the vertical counter.
- Counters and coordinates are 11-bit unsigned. Totals must not exceed 2047 (parameter check at elaboration).
- Mode handshake:
  - While idle, a cycle with `mode_req`=1 latches `mode_sel` into `pending` and sets `pend_valid`.
  - `mode_req`/`mode_sel` are ignored while `pend_valid` is set.
  - The pending mode is applied on the last cycle of a frame (h = H_TOTAL−1, v = V_TOTAL−1). The next cycle is position (0,0) of the new mode, with `mode_ack`=1 and `frame_start`=1.
  - A request for the mode already running is still acknowledged at the next frame boundary.
  - The requester drops `mode_req` on the cycle after `mode_ack`. A request still high then is treated as a new request.

## Timing
- All outputs are registered and aligned: an output at cycle n describes counter position n. There is no extra pipeline latency.
- Reset values: counters 0, both axes in FRONT, `mode_cur`=0, `pend_valid`=0, `hsync_n`=1, `vsync_n`=1, `disp_en`=0, `px_x`=`px_y`=0, `mode_ack`=0, `line_start`=0, `frame_start`=0.
- The first cycle after reset releases is position (0,0) with `line_start`=`frame_start`=1.
- Reset mid-frame or with a request pending discards the pending request; no `mode_ack` is issued.
- If a request is accepted on the frame's last cycle, it is latched, not applied; it takes effect one frame later.

## Configuration
- `VGA_SYNC_POL_EN` defined:
  - Adds per-mode parameters `MODEx_HSYNC_POS` and `MODEx_VSYNC_POS`. Defaults: mode 0 = 1/1, mode 1 = 0/0.
  - Sync outputs are driven active-high for modes whose parameter is 1.
  - Reset level of each sync output is its inactive level for mode 0.
- Undefined: both syncs are always active low, as described above.

## Structure
- Package `vga_timing_pkg`:
  - enum `vga_phase_t` {FRONT, SYNC, BACK, DISP};
  - `COORD_W` = 11;
  - struct `vga_axis_cfg_t` {disp, front, sync, back};
  - function `axis_total()`.
- Sub-module `vga_axis_counter`, instantiated twice (horizontal, vertical):
  - inputs: advance enable, load of a new `vga_axis_cfg_t`;
  - outputs: count, phase, wrap flag, active coordinate.
- The top level holds the mode-handshake logic and the output registers.

## Test plan
- Reset held 3 cycles, then released → outputs at their reset values during reset. First cycle after release: `frame_start`=1, `hsync_n`=1, `disp_en`=0.
- Mode 0, one line → `hsync_n` low for h = 48…159 (112 cycles). `disp_en` high for h = 408…1687 (during vertical DISP). `px_x` runs 0…1279. `line_start` repeats every 1688 cycles.
- Mode 0, full frame → `vsync_n` low for lines 1…3. `px_y` runs 0…1023. Frame length = 1688 × 1066 cycles.
- `mode_req`=1, `mode_sel`=1 at line 500 → no change until the frame ends. Then one `mode_ack` pulse aligned with `frame_start`, `mode_cur`=1, and the next line length is 800 cycles.
- Reset asserted mid-frame while a request is pending → counters return to (0,0), `mode_cur`=0, `mode_ack` never pulses.
- Build with `VGA_SYNC_POL_EN`, switch to mode 0 → `hsync_n` high only during h = 48…159.
